uart_transmitter: RTL and testbench

UART_TRANSMITTER -- requirements
Module: uart_transmitter

---
 rtl/uart_transmitter.sv | 164 ++++++++++++++++
 tb/tb_uart_transmitter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// UART transmitter: start, 5..8 LSB-first data bits, optional parity, 1 or 2 stop bits.
// One rising edge of tx_tick is one bit period. Define UART_TX_BREAK_EN to add the tx_break input.
module uart_transmitter (
  input  logic       tx_tick,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] parity_type,
  input  logic [3:0] frame_length,
  input  logic       stop_bit_type,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
`ifdef UART_TX_BREAK_EN
  input  logic       tx_break,
`endif
  output logic       tx_out,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned LEN_W  = 4;
  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(5);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(8);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK_HOLD
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [DATA_W-1:0]  r_data;
  logic [1:0]         r_parity;
  logic [CNT_W-1:0]   r_len_m1;
  logic               r_two_stop;
  logic [CNT_W-1:0]   r_bit_cnt;

  logic [CNT_W-1:0]   w_len_m1;
  logic [DATA_W-1:0]  w_mask;
  logic [CNT_W-1:0]   w_next_cnt;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_next_out;
  logic               w_next_done;
  logic               w_load;
  logic               w_par_en;
  logic               w_par_bit;
  logic               w_break;

`ifdef UART_TX_BREAK_EN
  assign w_break = tx_break;
`else
  assign w_break = 1'b0;
`endif

  // Clamp the requested length to 5..8, stored as (length - 1)
  always_comb begin
    w_len_m1 = CNT_W'(frame_length - LEN_W'(1));
    if (frame_length < MIN_LEN) begin
      w_len_m1 = CNT_W'(4);
    end else if (frame_length > MAX_LEN) begin
      w_len_m1 = CNT_W'(7);
    end
    w_mask = DATA_W'(8'hFF >> (CNT_W'(7) - w_len_m1));
  end

  // Unsent bits are masked off at latch time, so parity covers only transmitted bits
  assign w_par_en  = r_parity[0] ^ r_parity[1];
  assign w_par_bit = (^r_data) ^ r_parity[0];
  assign w_cnt_inc = r_bit_cnt + CNT_W'(1);

  always_ff @(posedge tx_tick or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      tx_out     <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      r_bit_cnt  <= '0;
      r_data     <= '0;
      r_parity   <= '0;
      r_len_m1   <= '0;
      r_two_stop <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      tx_out    <= w_next_out;
      tx_busy   <= (w_next_state != IDLE);
      tx_done   <= w_next_done;
      r_bit_cnt <= w_next_cnt;
      if (w_load) begin
        r_data     <= tx_data & w_mask;
        r_parity   <= parity_type;
        r_len_m1   <= w_len_m1;
        r_two_stop <= stop_bit_type;
      end
    end
  end

  // Next state plus the line level and done flag that go with it
  always_comb begin
    w_next_state = r_state;
    w_next_out   = 1'b1;
    w_next_done  = 1'b0;
    w_next_cnt   = r_bit_cnt;
    w_load       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_break) begin
          w_next_state = BREAK_HOLD;
          w_next_out   = 1'b0;
        end else if (tx_start) begin
          w_next_state = START;
          w_next_out   = 1'b0;
          w_load       = 1'b1;
        end
      end
      START: begin
        w_next_state = DATA;
        w_next_cnt   = '0;
        w_next_out   = r_data[0];
      end
      DATA: begin
        if (r_bit_cnt == r_len_m1) begin
          if (w_par_en) begin
            w_next_state = PARITY;
            w_next_out   = w_par_bit;
          end else begin
            w_next_state = STOP1;
          end
        end else begin
          w_next_cnt = w_cnt_inc;
          w_next_out = r_data[w_cnt_inc];
        end
      end
      PARITY: w_next_state = STOP1;
      STOP1: begin
        if (r_two_stop) begin
          w_next_state = STOP2;
        end else begin
          w_next_state = IDLE;
          w_next_done  = 1'b1;
        end
      end
      STOP2: begin
        w_next_state = IDLE;
        w_next_done  = 1'b1;
      end
      BREAK_HOLD: begin
        // Release passes through IDLE so the line is high for a tick before any start
        if (w_break) begin
          w_next_out = 1'b0;
        end else begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
    if (!enable) begin
      w_next_state = IDLE;
      w_next_out   = 1'b1;
      w_next_done  = 1'b0;
      w_load       = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: expected line/busy/done per tick kept in a queue.
// Build with +define+UART_TX_BREAK_EN to also exercise the break feature.
module tb_uart_transmitter;

  logic       tx_tick;
  logic       rst;
  logic       enable;
  logic [1:0] parity_type;
  logic [3:0] frame_length;
  logic       stop_bit_type;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_out;
  logic       tx_busy;
  logic       tx_done;
`ifdef UART_TX_BREAK_EN
  logic       tx_break;
`endif

  typedef struct packed {
    logic out;
    logic busy;
    logic done;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  uart_transmitter dut (
    .tx_tick      (tx_tick),
    .rst          (rst),
    .enable       (enable),
    .parity_type  (parity_type),
    .frame_length (frame_length),
    .stop_bit_type(stop_bit_type),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
`ifdef UART_TX_BREAK_EN
    .tx_break     (tx_break),
`endif
    .tx_out       (tx_out),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done)
  );

  initial tx_tick = 1'b0;
  always #5 tx_tick = ~tx_tick;

  // Reference model: one queue entry per tick of the frame, then the done tick
  function automatic void push_frame(input logic [7:0] d, input logic [3:0] len,
                                     input logic [1:0] par, input logic stop);
    int   n;
    logic x;
    n = (len < 4'd5) ? 5 : ((len > 4'd8) ? 8 : int'(len));
    x = 1'b0;
    exp_q.push_back('{out: 1'b0, busy: 1'b1, done: 1'b0});
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{out: d[i], busy: 1'b1, done: 1'b0});
      x = x ^ d[i];
    end
    if (par == 2'b01) exp_q.push_back('{out: ~x, busy: 1'b1, done: 1'b0});
    if (par == 2'b10) exp_q.push_back('{out: x, busy: 1'b1, done: 1'b0});
    exp_q.push_back('{out: 1'b1, busy: 1'b1, done: 1'b0});
    if (stop) exp_q.push_back('{out: 1'b1, busy: 1'b1, done: 1'b0});
    exp_q.push_back('{out: 1'b1, busy: 1'b0, done: 1'b1});
  endfunction

  // Consume the queue one tick at a time; entered at the negedge of the first expected tick
  task automatic check_stream(input string name);
    exp_t e;
    int   idx;
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({tx_out, tx_busy, tx_done} !== {e.out, e.busy, e.done}) begin
        n_fail++;
        $display("FAIL %s tick %0d: out/busy/done=%b%b%b expected %b%b%b",
                 name, idx, tx_out, tx_busy, tx_done, e.out, e.busy, e.done);
      end
      idx++;
      if (exp_q.size() > 0) @(negedge tx_tick);
    end
  endtask

  task automatic check_idle(input string name, input int ticks);
    for (int i = 0; i < ticks; i++) begin
      @(negedge tx_tick);
      n_checks++;
      if ({tx_out, tx_busy, tx_done} !== 3'b100) begin
        n_fail++;
        $display("FAIL %s idle tick %0d: out/busy/done=%b%b%b expected 100",
                 name, i, tx_out, tx_busy, tx_done);
      end
    end
  endtask

  // Called at a negedge; returns at the negedge where the START bit is on the line
  task automatic start_frame(input logic [7:0] d, input logic [3:0] len,
                             input logic [1:0] par, input logic stop);
    tx_data       = d;
    frame_length  = len;
    parity_type   = par;
    stop_bit_type = stop;
    tx_start      = 1'b1;
    push_frame(d, len, par, stop);
    @(negedge tx_tick);
    tx_start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge tx_tick);
    n_checks++;
    if ({tx_out, tx_busy, tx_done} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_state: out/busy/done=%b%b%b expected 100", tx_out, tx_busy, tx_done);
    end
    rst = 1'b0;
    check_idle("after_reset", 2);
  endtask

  task automatic test_basic();
    start_frame(8'hA5, 4'd8, 2'b00, 1'b0);
    check_stream("a5_8n1");
    check_idle("a5_after", 1);
    start_frame(8'h3C, 4'd6, 2'b11, 1'b0);
    check_stream("3c_par11_none");
    check_idle("3c_after", 1);
  endtask

  task automatic test_parity_config_hold();
    start_frame(8'h1F, 4'd5, 2'b10, 1'b1);
    tx_data       = 8'h00;
    frame_length  = 4'd8;
    parity_type   = 2'b00;
    stop_bit_type = 1'b0;
    check_stream("1f_5e2_cfg_change");
    check_idle("1f_after", 1);
    start_frame(8'h03, 4'd8, 2'b01, 1'b0);
    check_stream("03_8o1");
    check_idle("03_after", 1);
  endtask

  task automatic test_clamp();
    start_frame(8'h03, 4'd15, 2'b01, 1'b0);
    check_stream("03_len15_clamp8");
    check_idle("len15_after", 1);
    start_frame(8'hFF, 4'd2, 2'b10, 1'b0);
    check_stream("ff_len2_clamp5");
    check_idle("len2_after", 1);
  endtask

  task automatic test_back_to_back();
    start_frame(8'h55, 4'd8, 2'b00, 1'b0);
    tx_start = 1'b1;
    tx_data  = 8'hAA;
    push_frame(8'hAA, 4'd8, 2'b00, 1'b0);
    check_stream("b2b_55_aa");
    tx_start = 1'b0;
    check_idle("b2b_after", 2);
  endtask

  task automatic test_enable_drop();
    start_frame(8'hA5, 4'd8, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) exp_q.pop_back();
    while (exp_q.size() > 3) exp_q.pop_back();
    check_stream("en_drop_prefix");
    enable = 1'b0;
    check_idle("en_drop", 1);
    enable = 1'b1;
    check_idle("en_drop_after", 3);
  endtask

  task automatic test_reset_midframe();
    start_frame(8'hFF, 4'd8, 2'b00, 1'b0);
    while (exp_q.size() > 5) exp_q.pop_back();
    check_stream("rst_prefix");
    rst = 1'b1;
    #1;
    n_checks++;
    if ({tx_out, tx_busy, tx_done} !== 3'b100) begin
      n_fail++;
      $display("FAIL rst_async: out/busy/done=%b%b%b expected 100", tx_out, tx_busy, tx_done);
    end
    @(negedge tx_tick);
    rst = 1'b0;
    check_idle("rst_after", 3);
    start_frame(8'h96, 4'd7, 2'b01, 1'b1);
    check_stream("rst_next_frame");
    check_idle("rst_next_after", 1);
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break();
    tx_break      = 1'b1;
    tx_start      = 1'b1;
    tx_data       = 8'h5A;
    frame_length  = 4'd8;
    parity_type   = 2'b00;
    stop_bit_type = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge tx_tick);
      n_checks++;
      if ({tx_out, tx_busy, tx_done} !== 3'b010) begin
        n_fail++;
        $display("FAIL break tick %0d: out/busy/done=%b%b%b expected 010",
                 i, tx_out, tx_busy, tx_done);
      end
    end
    tx_break = 1'b0;
    @(negedge tx_tick);
    n_checks++;
    if ({tx_out, tx_busy, tx_done} !== 3'b100) begin
      n_fail++;
      $display("FAIL break_release: out/busy/done=%b%b%b expected 100", tx_out, tx_busy, tx_done);
    end
    push_frame(8'h5A, 4'd8, 2'b00, 1'b0);
    @(negedge tx_tick);
    tx_start = 1'b0;
    check_stream("after_break_frame");
    check_idle("break_after", 1);
  endtask
`endif

  initial begin
    rst           = 1'b1;
    enable        = 1'b1;
    parity_type   = 2'b00;
    frame_length  = 4'd8;
    stop_bit_type = 1'b0;
    tx_start      = 1'b0;
    tx_data       = 8'h00;
`ifdef UART_TX_BREAK_EN
    tx_break      = 1'b0;
`endif
    test_reset();
    test_basic();
    test_parity_config_hold();
    test_clamp();
    test_back_to_back();
    test_enable_drop();
    test_reset_midframe();
`ifdef UART_TX_BREAK_EN
    test_break();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
